// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, command bytes, counter widths
// and the odd-parity frame builder used by the host transmitter.
package ps2_host_tx_pkg;

  localparam int TIMER_W = 21;
  localparam int EDGE_W  = 4;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INHIBIT   = 4'd1;
  localparam logic [3:0] ST_RTS       = 4'd2;
  localparam logic [3:0] ST_WAIT_CLK  = 4'd3;
  localparam logic [3:0] ST_SHIFT     = 4'd4;
  localparam logic [3:0] ST_ACK       = 4'd5;
  localparam logic [3:0] ST_WAIT_IDLE = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;
  localparam logic [3:0] ST_ERR       = 4'd8;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Bit 8 makes the total number of ones across all nine bits odd.
  function automatic logic [8:0] make_frame(input logic [7:0] data);
    return {~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// strobe on the synchronized clock; shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta_r;
  logic clk_sync_r;
  logic clk_prev_r;
  logic data_meta_r;
  logic data_sync_r;

  // Idle bus level is high, so the chain resets high to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign clk_sync  = clk_sync_r;
  assign data_sync = data_sync_r;
  assign clk_fall  = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame,
// acknowledge check, with start and transfer timeouts.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int RTS_CYCLES     = 20,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_host_tx_if.slave      tx,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe
);

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RTS_LAST     = TIMER_W'(RTS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX    = {TIMER_W{1'b1}};

  logic                clk_sync_s;
  logic                data_sync_s;
  logic                clk_fall_s;

  logic [3:0]          state_r,    state_s;
  logic [TIMER_W-1:0]  timer_r,    timer_s,    timer_inc_s;
  logic [EDGE_W-1:0]   edge_cnt_r, edge_cnt_s;
  logic [8:0]          frame_r,    frame_s;
  logic                shift_oe_s;

  logic clk_oe_r,  clk_oe_s;
  logic data_oe_r, data_oe_s;
  logic ready_r,   ready_s;
  logic busy_r,    busy_s;
  logic done_r,    done_s;
  logic err_r,     err_s;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync_s),
    .data_sync   (data_sync_s),
    .clk_fall    (clk_fall_s)
  );

  assign timer_inc_s = (timer_r == TIMER_MAX) ? timer_r : timer_r + 21'd1;

  // Next-state, timer, edge counter and data-line level; edges beat timeouts.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_inc_s;
    edge_cnt_s = edge_cnt_r;
    frame_s    = frame_r;
    shift_oe_s = data_oe_r;
    case (state_r)
      ST_IDLE: begin
        timer_s = {TIMER_W{1'b0}};
        if (tx.tx_valid) begin
          frame_s    = make_frame(tx.tx_data);
          edge_cnt_s = 4'd0;
          state_s    = ST_INHIBIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (timer_r == INHIBIT_LAST) begin
          state_s = ST_RTS;
          timer_s = {TIMER_W{1'b0}};
        end else begin
          state_s = ST_INHIBIT;
        end
      end
      ST_RTS: begin
        if (timer_r == RTS_LAST) begin
          state_s = ST_WAIT_CLK;
          timer_s = {TIMER_W{1'b0}};
        end else begin
          state_s = ST_RTS;
        end
      end
      ST_WAIT_CLK: begin
        if (clk_fall_s) begin
          state_s    = ST_SHIFT;
          timer_s    = {TIMER_W{1'b0}};
          edge_cnt_s = 4'd1;
          shift_oe_s = ~frame_r[0];
        end else if (timer_r == START_LAST) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_WAIT_CLK;
        end
      end
      ST_SHIFT: begin
        if (clk_fall_s) begin
          if (edge_cnt_r == 4'd9) begin
            shift_oe_s = 1'b0;
            edge_cnt_s = 4'd10;
            state_s    = ST_ACK;
          end else begin
            shift_oe_s = ~frame_r[edge_cnt_r];
            edge_cnt_s = edge_cnt_r + 4'd1;
          end
        end else if (timer_r == XFER_LAST) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_ACK: begin
        if (clk_fall_s) begin
          if (!data_sync_s) begin
            state_s = ST_WAIT_IDLE;
          end else begin
            state_s = ST_ERR;
          end
        end else if (timer_r == XFER_LAST) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_sync_s && data_sync_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    clk_oe_s  = 1'b0;
    data_oe_s = 1'b0;
    ready_s   = 1'b0;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    err_s     = 1'b0;
    case (state_s)
      ST_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      ST_INHIBIT:  clk_oe_s = 1'b1;
      ST_RTS: begin
        clk_oe_s  = 1'b1;
        data_oe_s = 1'b1;
      end
      ST_WAIT_CLK: data_oe_s = 1'b1;
      ST_SHIFT:    data_oe_s = shift_oe_s;
      ST_DONE:     done_s    = 1'b1;
      ST_ERR:      err_s     = 1'b1;
      default:     data_oe_s = 1'b0;
    endcase
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      timer_r    <= {TIMER_W{1'b0}};
      edge_cnt_r <= 4'd0;
      frame_r    <= 9'd0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      edge_cnt_r <= edge_cnt_s;
      frame_r    <= frame_s;
      clk_oe_r   <= clk_oe_s;
      data_oe_r  <= data_oe_s;
      ready_r    <= ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign tx.tx_ready = ready_r;
  assign tx.tx_busy  = busy_r;
  assign tx.tx_done  = done_r;
  assign tx.tx_err   = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// a per-cycle monitor checks the handshake and line drive against frame timing.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH   = 100;
  localparam int RTS   = 10;
  localparam int START = 5000;
  localparam int XFER  = 20000;
  localparam int HALF  = 20;  // device half period, scaled down for run time

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_in, ps2_data_in;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if tx_bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTS),
    .START_TIMEOUT  (START),
    .XFER_TIMEOUT   (XFER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx          (tx_bus),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc = 0;
  int t_rel = 0;
  int pulses = 0;
  int exp_err_t = 0;
  bit active = 1'b0;
  bit exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line order on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_bits(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    wait_cyc(1);
    tx_bus.tx_data  = b;
    tx_bus.tx_valid = 1'b1;
    wait_cyc(1);
    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_data  = 8'($urandom);
  endtask

  task automatic device(input int n_edges, input bit ack, output logic [10:0] bits);
    int k;
    bits = 11'd0;
    k = 0;
    while (!(ps2_clk_in && !ps2_data_in) && k < 1000) begin
      wait_cyc(1);
      k++;
    end
    chk("device_rts_seen", {30'd0, ps2_clk_in, ps2_data_in}, 32'd2);
    for (int i = 0; i < n_edges; i++) begin
      wait_cyc(HALF);
      bits[i] = ps2_data_in;
      if (i == 10 && ack) begin
        dev_data_low = 1'b1;
        wait_cyc(2);
      end
      dev_clk_low = 1'b1;
      if (i < n_edges - 1 || n_edges == 11) begin
        wait_cyc(HALF);
        dev_clk_low = 1'b0;
      end
    end
    if (n_edges == 11) begin
      wait_cyc(HALF);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input int n);
    int k;
    k = 0;
    while (active && k < n) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("wait_idle_bound", {31'd0, active}, 32'd0);
  endtask

  task automatic frame(input logic [7:0] b, input bit ack, output logic [10:0] bits);
    int p0;
    p0 = pulses;
    exp_err = !ack;
    exp_err_t = 0;
    fork
      send(b);
      device(11, ack, bits);
    join
    wait_idle(3000);
    chk("frame_bits", {21'd0, bits}, {21'd0, exp_bits(b)});
    chk("frame_pulses", pulses - p0, 32'd1);
  endtask

  // Per-cycle monitor: expected drive follows from cycles since acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 1'b0;
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_bus.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, tx_bus.tx_busy}, 32'd0);
        chk("rst_pulses", {30'd0, tx_bus.tx_done, tx_bus.tx_err}, 32'd0);
      end else if (active) begin
        t_rel = cyc - acc + 1;
        chk("busy_ready", {30'd0, tx_bus.tx_busy, tx_bus.tx_ready}, 32'd2);
        if (t_rel <= INH)
          chk("inhibit_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd2);
        else if (t_rel <= INH + RTS)
          chk("rts_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd3);
        else
          chk("clk_released", {31'd0, ps2_clk_oe}, 32'd0);
        if (tx_bus.tx_done || tx_bus.tx_err) begin
          pulses++;
          chk("pulse_kind", {30'd0, tx_bus.tx_done, tx_bus.tx_err}, exp_err ? 32'd1 : 32'd2);
          chk("pulse_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
          if (exp_err_t != 0) chk("timeout_at", t_rel, exp_err_t);
          active = 1'b0;
        end
      end else begin
        chk("idle_ready_busy", {30'd0, tx_bus.tx_ready, tx_bus.tx_busy}, 32'd2);
        chk("idle_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("idle_pulses", {30'd0, tx_bus.tx_done, tx_bus.tx_err}, 32'd0);
        if (tx_bus.tx_valid) begin
          active = 1'b1;
          acc = cyc + 1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    int p0;
    tx_bus.tx_data  = 8'h00;
    tx_bus.tx_valid = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    wait_cyc(2);
    chk("reset_ready", {31'd0, tx_bus.tx_ready}, 32'd1);

    frame(CMD_ENABLE, 1'b1, bits);
    chk("f4_literal", {21'd0, bits}, 32'h5E8);

    frame(CMD_RESET, 1'b1, bits);
    chk("ff_literal", {21'd0, bits}, 32'h7FE);

    frame(8'($urandom), 1'b0, bits);

    exp_err = 1'b1;
    exp_err_t = INH + RTS + 1 + START;
    p0 = pulses;
    send(CMD_SET_LEDS);
    wait_idle(START + 1000);
    chk("start_timeout_pulses", pulses - p0, 32'd1);
    exp_err_t = 0;

    exp_err = 1'b0;
    p0 = pulses;
    fork
      send(CMD_ENABLE);
      device(4, 1'b1, bits);
    join
    wait_cyc(6);
    chk("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    dev_clk_low = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    chk("reset_no_pulse", pulses - p0, 32'd0);
    frame(CMD_SET_LEDS, 1'b1, bits);
    chk("ed_literal", {21'd0, bits}, 32'h7DA);

    p0 = pulses;
    exp_err = 1'b0;
    fork
      send(CMD_ENABLE);
      device(11, 1'b1, bits);
      begin
        wait_cyc(300);
        tx_bus.tx_data  = 8'h00;
        tx_bus.tx_valid = 1'b1;
        wait_cyc(100);
        tx_bus.tx_valid = 1'b0;
      end
    join
    wait_idle(3000);
    chk("busy_ignore_bits", {21'd0, bits}, 32'h5E8);
    chk("busy_ignore_pulses", pulses - p0, 32'd1);

    for (int i = 0; i < 4; i++) begin
      frame(8'($urandom), 1'($urandom_range(0, 1)), bits);
    end

    wait_cyc(5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
